if_xfer_sched: RTL



---
 rtl/if_sched_pkg.sv | 38 +++
 rtl/gbf_occ_check.sv | 24 ++
 rtl/if_xfer_sched.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/if_sched_pkg.sv
// Shared interface target codes, scheduler state encoding and GBF buffer indices
// for the off-chip interface transfer scheduler.
package if_sched_pkg;

  localparam logic [3:0] CODE_CFG    = 4'd0;
  localparam logic [3:0] CODE_FLGWEI = 4'd8;
  localparam logic [3:0] CODE_WEI    = 4'd6;
  localparam logic [3:0] CODE_FLGACT = 4'd4;
  localparam logic [3:0] CODE_ACT    = 4'd2;
  localparam logic [3:0] CODE_FLGOFM = 4'd10;
  localparam logic [3:0] CODE_OFM    = 4'd11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int BUF_FLGWEI = 0;
  localparam int BUF_WEI    = 1;
  localparam int BUF_FLGACT = 2;
  localparam int BUF_ACT    = 3;
  localparam int BUF_FLGOFM = 4;
  localparam int BUF_OFM    = 5;
  localparam int NUM_BUF    = 6;

  // Round-robin slot (0..3) to the target code of that fill buffer.
  function automatic logic [3:0] fill_code(input logic [1:0] idx);
    case (idx)
      2'd0:    fill_code = CODE_FLGWEI;
      2'd1:    fill_code = CODE_WEI;
      2'd2:    fill_code = CODE_FLGACT;
      default: fill_code = CODE_ACT;
    endcase
  endfunction

endpackage

// File: rtl/gbf_occ_check.sv
// Occupancy / free-space threshold test for one global buffer; equal pointers mean empty,
// so a fill buffer can hold at most 2^ADDR_W - 1 words.
module gbf_occ_check #(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic [ADDR_W-1:0] addr_rd,
  input  logic              mode,
  input  logic [ADDR_W:0]   threshold,
  input  logic              mask,
  output logic              elig
);

  logic [ADDR_W-1:0] occ;
  logic [ADDR_W-1:0] free;

  assign occ  = addr_wr - addr_rd;
  // 2^ADDR_W - 1 - occ is exactly the bitwise complement at ADDR_W bits.
  assign free = ~occ;

  assign elig = !mask && (mode ? ({1'b0, free} >= threshold)
                               : ({1'b0, occ}  >= threshold));

endmodule

// File: rtl/if_xfer_sched.sv
// Chooses which GBF the shared SPI/async-FIFO path serves next (config, drains, then
// round-robin fills) and issues one request per burst to the interface.
module if_xfer_sched
  import if_sched_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int IN_BURST  = 64,
  parameter int OUT_BURST = 64,
  parameter int ACK_TO    = 15
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Reset_WEI,
  input  logic              Reset_ACT,
  input  logic              Reset_OFM,
  input  logic              CFG_Req,
  input  logic              IF_Rdy,
  input  logic [ADDR_W-1:0] GBFFLGWEI_AddrWr,
  input  logic [ADDR_W-1:0] GBFWEI_AddrWr,
  input  logic [ADDR_W-1:0] GBFFLGACT_AddrWr,
  input  logic [ADDR_W-1:0] GBFACT_AddrWr,
  input  logic [ADDR_W-1:0] GBFFLGOFM_AddrWr,
  input  logic [ADDR_W-1:0] GBFOFM_AddrWr,
  input  logic [ADDR_W-1:0] GBFFLGWEI_AddrRd,
  input  logic [ADDR_W-1:0] GBFWEI_AddrRd,
  input  logic [ADDR_W-1:0] GBFFLGACT_AddrRd,
  input  logic [ADDR_W-1:0] GBFACT_AddrRd,
  input  logic [ADDR_W-1:0] GBFFLGOFM_AddrRd,
  input  logic [ADDR_W-1:0] GBFOFM_AddrRd,
  output logic              IF_Req,
  output logic [3:0]        IF_Cfg,
  output logic              IF_RdWr,
  output logic              Busy
);

  localparam int CNT_W = $clog2(ACK_TO + 1);
  localparam logic [ADDR_W:0] IN_THR  = (ADDR_W+1)'(IN_BURST);
  localparam logic [ADDR_W:0] OUT_THR = (ADDR_W+1)'(OUT_BURST);

  logic [ADDR_W-1:0] wr_ptr [NUM_BUF];
  logic [ADDR_W-1:0] rd_ptr [NUM_BUF];
  logic [5:0]        mask;
  logic [5:0]        elig_now;
  logic [5:0]        elig;
  logic [3:0]        fill_elig;

  state_t            state, state_next;
  logic [1:0]        rr, rr_idx;
  logic              rr_hit;
  logic              cfg_pend;
  logic [CNT_W-1:0]  ack_cnt, ack_cnt_next;
  logic              grant, grant_cfg, grant_fill, grant_rdwr;
  logic [3:0]        grant_code;

  assign wr_ptr[BUF_FLGWEI] = GBFFLGWEI_AddrWr;
  assign wr_ptr[BUF_WEI]    = GBFWEI_AddrWr;
  assign wr_ptr[BUF_FLGACT] = GBFFLGACT_AddrWr;
  assign wr_ptr[BUF_ACT]    = GBFACT_AddrWr;
  assign wr_ptr[BUF_FLGOFM] = GBFFLGOFM_AddrWr;
  assign wr_ptr[BUF_OFM]    = GBFOFM_AddrWr;
  assign rd_ptr[BUF_FLGWEI] = GBFFLGWEI_AddrRd;
  assign rd_ptr[BUF_WEI]    = GBFWEI_AddrRd;
  assign rd_ptr[BUF_FLGACT] = GBFFLGACT_AddrRd;
  assign rd_ptr[BUF_ACT]    = GBFACT_AddrRd;
  assign rd_ptr[BUF_FLGOFM] = GBFFLGOFM_AddrRd;
  assign rd_ptr[BUF_OFM]    = GBFOFM_AddrRd;

  // Each pointer-clear strobe covers a flag/data buffer pair.
  assign mask = {Reset_OFM, Reset_OFM, Reset_ACT, Reset_ACT, Reset_WEI, Reset_WEI};

  for (genvar i = 0; i < NUM_BUF; i++) begin : g_occ
    gbf_occ_check #(.ADDR_W(ADDR_W)) u_chk (
      .addr_wr   (wr_ptr[i]),
      .addr_rd   (rd_ptr[i]),
      .mode      ((i < BUF_FLGOFM) ? 1'b1 : 1'b0),
      .threshold ((i < BUF_FLGOFM) ? IN_THR : OUT_THR),
      .mask      (mask[i]),
      .elig      (elig_now[i])
    );
  end

  assign fill_elig = elig[3:0];

  always_comb begin
    rr_hit = 1'b0;
    rr_idx = rr;
    for (int k = 0; k < 4; k++) begin
      if (!rr_hit && fill_elig[rr + 2'(k)]) begin
        rr_hit = 1'b1;
        rr_idx = rr + 2'(k);
      end
    end
  end

  always_comb begin
    state_next   = state;
    ack_cnt_next = ack_cnt;
    grant        = 1'b0;
    grant_cfg    = 1'b0;
    grant_fill   = 1'b0;
    grant_code   = CODE_CFG;
    grant_rdwr   = 1'b1;
    case (state)
      IDLE: begin
        if (IF_Rdy && (cfg_pend || (|elig))) begin
          grant        = 1'b1;
          state_next   = ISSUE;
          ack_cnt_next = '0;
          if (cfg_pend) begin
            grant_cfg = 1'b1;
          end else if (elig[BUF_FLGOFM]) begin
            grant_code = CODE_FLGOFM;
            grant_rdwr = 1'b0;
          end else if (elig[BUF_OFM]) begin
            grant_code = CODE_OFM;
            grant_rdwr = 1'b0;
          end else begin
            grant_fill = 1'b1;
            grant_code = fill_code(rr_idx);
          end
        end
      end
      ISSUE: state_next = WAIT_ACK;
      WAIT_ACK: begin
        // A silent interface is treated as having completed the burst.
        if (!IF_Rdy)                               state_next = WAIT_DONE;
        else if (ack_cnt == CNT_W'(ACK_TO - 1))    state_next = IDLE;
        else                                       ack_cnt_next = ack_cnt + CNT_W'(1);
      end
      WAIT_DONE: if (IF_Rdy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= IDLE;
      rr       <= 2'd0;
      cfg_pend <= 1'b0;
      elig     <= '0;
      ack_cnt  <= '0;
      IF_Cfg   <= CODE_CFG;
      IF_RdWr  <= 1'b1;
    end else begin
      state    <= state_next;
      ack_cnt  <= ack_cnt_next;
      elig     <= elig_now;
      cfg_pend <= CFG_Req | (cfg_pend & ~grant_cfg);
      if (grant) begin
        IF_Cfg  <= grant_code;
        IF_RdWr <= grant_rdwr;
      end
      if (grant_fill) rr <= rr_idx + 2'd1;
    end
  end

  assign IF_Req = (state == ISSUE);
  assign Busy   = (state != IDLE);

endmodule
